// File: rtl/snake_window_pkg.sv
// Shared types for the serpentine 3x3 window generator.
// State encoding, dimension limits and window bit-offset helper.
package snake_window_pkg;

  localparam int ROW_MAX = 511;
  localparam int COL_MAX = 511;

  typedef enum logic [2:0] {
    SW_IDLE,
    SW_FILL,
    SW_RIGHT,
    SW_DOWN,
    SW_LEFT,
    SW_DONE
  } sw_state_e;

  // Bit offset of window pixel (r,c), r=0 top, c=0 left.
  function automatic int unsigned win_off(
    input int unsigned r,
    input int unsigned c,
    input int unsigned dw
  );
    return (3 * r + c) * dw;
  endfunction

endpackage

// File: rtl/win_reg3x3.sv
// 3x3 pixel register array for snake_window.
// Shifts left, right or up with a 3-pixel load, or clears.
module win_reg3x3
  import snake_window_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            i_clk,
  input  logic            i_clr,
  input  logic            i_shl,
  input  logic            i_shr,
  input  logic            i_up,
  input  logic [3*DW-1:0] i_load,
  output logic [9*DW-1:0] o_win
);

  logic [DW-1:0] r_px [3][3];

  // One operation per cycle; clear wins, then left, right, up.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_px[r][c] <= '0;
        end
      end
    end else if (i_shl) begin
      for (int r = 0; r < 3; r++) begin
        r_px[r][0] <= r_px[r][1];
        r_px[r][1] <= r_px[r][2];
        r_px[r][2] <= i_load[r*DW +: DW];
      end
    end else if (i_shr) begin
      for (int r = 0; r < 3; r++) begin
        r_px[r][2] <= r_px[r][1];
        r_px[r][1] <= r_px[r][0];
        r_px[r][0] <= i_load[r*DW +: DW];
      end
    end else if (i_up) begin
      for (int c = 0; c < 3; c++) begin
        r_px[0][c] <= r_px[1][c];
        r_px[1][c] <= r_px[2][c];
        r_px[2][c] <= i_load[c*DW +: DW];
      end
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign o_win[win_off(r, c, DW) +: DW] = r_px[r][c];
    end
  end

endmodule

// File: rtl/snake_window.sv
// Serpentine 3x3 window generator: FSM, position counters and
// output registers around a shifting 3x3 pixel array.
module snake_window
  import snake_window_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CW-1:0]   col,
  input  logic [CW-1:0]   row,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3*DW-1:0] in_data,
  output logic            out_valid,
  output logic [9*DW-1:0] win_out,
  output logic [CW-1:0]   out_wrow,
  output logic [CW-1:0]   out_wcol,
  output logic            out_dir,
  output logic            done
);

  sw_state_e r_state;
  sw_state_e w_nstate;
  sw_state_e w_eor_ns;

  logic [CW-1:0] r_colm3;
  logic [CW-1:0] r_rowm3;
  logic [1:0]    r_fcnt;
  logic [CW-1:0] r_wrow;
  logic [CW-1:0] r_wcol;
  logic          r_out_valid;
  logic          r_dir;

  logic          w_ready;
  logic          w_take;
  logic          w_emit;
  logic          w_shl;
  logic          w_shr;
  logic          w_up;
  logic [CW-1:0] w_nwrow;
  logic [CW-1:0] w_nwcol;
  logic          w_small;

  assign w_ready = en & ((r_state == SW_FILL)  |
                         (r_state == SW_RIGHT) |
                         (r_state == SW_DOWN)  |
                         (r_state == SW_LEFT));
  assign w_take  = in_valid & w_ready;
  assign w_small = (col < CW'(3)) | (row < CW'(3));

  // End of a horizontal run: finish on the last row, else turn down.
  assign w_eor_ns = (r_wrow == r_rowm3) ? SW_DONE : SW_DOWN;

  // Next state, array control and next window position.
  always_comb begin
    w_nstate = r_state;
    w_emit   = 1'b0;
    w_shl    = 1'b0;
    w_shr    = 1'b0;
    w_up     = 1'b0;
    w_nwrow  = r_wrow;
    w_nwcol  = r_wcol;
    unique case (r_state)
      SW_IDLE: begin
        if (en) begin
          w_nstate = w_small ? SW_DONE : SW_FILL;
        end
      end
      SW_FILL: begin
        if (w_take) begin
          w_shl = 1'b1;
          if (r_fcnt == 2'd2) begin
            w_emit  = 1'b1;
            w_nwrow = '0;
            w_nwcol = '0;
            w_nstate = (r_colm3 == '0) ? w_eor_ns : SW_RIGHT;
          end
        end
      end
      SW_RIGHT: begin
        if (w_take) begin
          w_shl   = 1'b1;
          w_emit  = 1'b1;
          w_nwcol = r_wcol + CW'(1);
          if (w_nwcol == r_colm3) begin
            w_nstate = w_eor_ns;
          end
        end
      end
      SW_DOWN: begin
        if (w_take) begin
          w_up    = 1'b1;
          w_emit  = 1'b1;
          w_nwrow = r_wrow + CW'(1);
          if (r_colm3 == '0) begin
            w_nstate = (w_nwrow == r_rowm3) ? SW_DONE : SW_DOWN;
          end else begin
            w_nstate = w_nwrow[0] ? SW_LEFT : SW_RIGHT;
          end
        end
      end
      SW_LEFT: begin
        if (w_take) begin
          w_shr   = 1'b1;
          w_emit  = 1'b1;
          w_nwcol = r_wcol - CW'(1);
          if (w_nwcol == '0) begin
            w_nstate = w_eor_ns;
          end
        end
      end
      SW_DONE: begin
        w_nstate = SW_DONE;
      end
      default: begin
        w_nstate = SW_IDLE;
      end
    endcase
    if (!en) begin
      w_nstate = SW_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SW_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // Dimension latch, fill count, position and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_colm3     <= '0;
      r_rowm3     <= '0;
      r_fcnt      <= '0;
      r_wrow      <= '0;
      r_wcol      <= '0;
      r_out_valid <= 1'b0;
      r_dir       <= 1'b0;
    end else if (!en) begin
      r_fcnt      <= '0;
      r_wrow      <= '0;
      r_wcol      <= '0;
      r_out_valid <= 1'b0;
      r_dir       <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      if (r_state == SW_IDLE) begin
        r_colm3 <= col - CW'(3);
        r_rowm3 <= row - CW'(3);
        r_fcnt  <= '0;
        r_wrow  <= '0;
        r_wcol  <= '0;
      end
      if (w_take && (r_state == SW_FILL)) begin
        r_fcnt <= r_fcnt + 2'd1;
      end
      if (w_emit) begin
        r_wrow <= w_nwrow;
        r_wcol <= w_nwcol;
        r_dir  <= w_nwrow[0];
      end
    end
  end

  win_reg3x3 #(
    .DW(DW)
  ) u_win (
    .i_clk  (clk),
    .i_clr  (~rst_n),
    .i_shl  (w_shl),
    .i_shr  (w_shr),
    .i_up   (w_up),
    .i_load (in_data),
    .o_win  (win_out)
  );

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_wrow  = r_wrow;
  assign out_wcol  = r_wcol;
  assign out_dir   = r_dir;
  assign done      = (r_state == SW_DONE);

endmodule
